// File: rtl/divs8_seq.sv
// -----------------------------------------------------------------------------
// divs8_seq -- sequential signed divider, 16-bit dividend / 8-bit divisor.
//
// Quotient is truncated toward zero and the remainder takes the sign of the
// dividend. The magnitudes go through an 8-step unsigned restoring divider,
// and the signs are applied afterwards. Every operation takes the same number
// of cycles: the divide-by-zero and overflow cases do not finish early.
//
// Ports:
//   clk    in   1   sole clock, rising edge
//   rst    in   1   asynchronous, active-high reset
//   start  in   1   request, sampled only in IDLE
//   a      in  16   signed dividend, captured with start
//   b      in   8   signed divisor, captured with start
//   q      out  8   signed quotient (registered)
//   r      out  8   signed remainder (registered)
//   busy   out  1   operation in flight
//   done   out  1   one-cycle pulse; q, r, ovf, dz valid
//   ovf    out  1   quotient not representable in 8-bit signed
//   dz     out  1   divisor was zero
// -----------------------------------------------------------------------------
module divs8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [7:0]  b,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        dz
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0] state;
    logic [7:0] cnt;      // iteration counter, 7 down to 0
    logic [8:0] rem;      // partial remainder
    logic [7:0] dvd;      // low dividend bits shift out, quotient bits shift in
    logic [8:0] bmag;     // |b|, 9 bits so that -128 becomes +128
    logic       neg_q;    // sign(a) ^ sign(b)
    logic       neg_r;    // sign(a)
    logic       dz_r;
    logic       pre_ovf;
    logic [7:0] q_res;
    logic [7:0] r_res;
    logic       ovf_res;

    // Magnitudes of the inputs. 17 bits hold |-32768| = 32768 exactly.
    logic [16:0] a_ext;
    logic [16:0] amag;
    logic [8:0]  b_ext;
    logic [8:0]  bmag_in;
    logic        pre_ovf_in;

    always_comb begin
        a_ext      = {a[15], a};
        amag       = a[15] ? (~a_ext + 17'd1) : a_ext;
        b_ext      = {b[7], b};
        bmag_in    = b[7] ? (~b_ext + 9'd1) : b_ext;
        // If the upper dividend bits already reach |b|, the quotient needs
        // more than 8 bits and cannot be produced by 8 iterations.
        pre_ovf_in = (b != 8'd0) && (amag[16:8] >= bmag_in);
    end

    // One restoring step: bring down the next dividend bit, then subtract
    // the divisor whenever it fits.
    logic [9:0] shifted;
    logic [9:0] diff;
    logic       fits;
    logic [8:0] rem_next;

    always_comb begin
        shifted  = {rem, dvd[7]};
        diff     = shifted - {1'b0, bmag};
        fits     = shifted >= {1'b0, bmag};
        rem_next = fits ? diff[8:0] : shifted[8:0];
    end

    // Sign fix-up. A negative quotient may reach magnitude 128; a positive
    // one only 127. The remainder magnitude is below |b| <= 128 and so is at
    // most 127, which always fits in 8 bits.
    logic       ovf_fix;
    logic [7:0] q_fix;
    logic [7:0] r_fix;

    always_comb begin
        ovf_fix = 1'b0;
        q_fix   = 8'h00;
        r_fix   = 8'h00;
        if (!dz_r) begin
            ovf_fix = pre_ovf || (neg_q ? (dvd > 8'd128) : (dvd > 8'd127));
            if (ovf_fix) begin
                q_fix = 8'h80;
            end else begin
                q_fix = neg_q ? (~dvd + 8'd1) : dvd;
                r_fix = neg_r ? (~rem[7:0] + 8'd1) : rem[7:0];
            end
        end
    end

    // NOTE: every register below is written with <= so that all of them
    // update together on the clock edge; a blocking write would let later
    // statements in the block see the new value within the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 8'd0;
            rem     <= 9'd0;
            dvd     <= 8'd0;
            bmag    <= 9'd0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz_r    <= 1'b0;
            pre_ovf <= 1'b0;
            q_res   <= 8'h00;
            r_res   <= 8'h00;
            ovf_res <= 1'b0;
            q       <= 8'h00;
            r       <= 8'h00;
            ovf     <= 1'b0;
            dz      <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rem     <= amag[16:8];
                        dvd     <= amag[7:0];
                        bmag    <= bmag_in;
                        neg_q   <= a[15] ^ b[7];
                        neg_r   <= a[15];
                        dz_r    <= (b == 8'd0);
                        pre_ovf <= pre_ovf_in;
                        cnt     <= 8'd7;
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem <= rem_next;
                    dvd <= {dvd[6:0], fits};
                    if (cnt == 8'd0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_FIX: begin
                    q_res   <= q_fix;
                    r_res   <= r_fix;
                    ovf_res <= ovf_fix;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    q     <= q_res;
                    r     <= r_res;
                    ovf   <= ovf_res;
                    dz    <= dz_r;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule
